// File: rtl/exe_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One bit per cycle: shift-add multiply and restoring divide, with a 32-cycle CALC phase.
module exe_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  localparam int CW = $clog2(XLEN);

  state_e            state;
  op_e               op_q;
  logic              neg_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;   // {partial product | remainder, multiplier | dividend}
  logic [XLEN-1:0]   opnd;  // multiplicand or divisor magnitude

  // Operand conditioning, evaluated on the raw inputs while IDLE.
  logic            sgn_a, sgn_b, is_rem, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sgn_a       = opA[XLEN-1] && (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    sgn_b       = opB[XLEN-1] && (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    mag_a       = sgn_a ? -opA : opA;
    mag_b       = sgn_b ? -opB : opB;
    is_rem      = op[2] & op[1];
    div_zero    = op[2] && (opB == '0);
    div_ovf     = (op == OP_DIV || op == OP_REM) &&
                  (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = is_rem ? opA : '1;
    else if (div_ovf && !is_rem)
      special_res = {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration of the datapath plus the final sign fix-up of its output.
  logic [XLEN:0]     mul_sum, div_part;
  logic [XLEN-1:0]   div_diff, div_val, div_fin, final_res;
  logic              div_borrow;
  logic [2*XLEN-1:0] acc_nxt, prod;

  always_comb begin
    mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_part   = acc[2*XLEN-1:XLEN-1];
    div_borrow = div_part < {1'b0, opnd};
    div_diff   = div_part[XLEN-1:0] - opnd;
    if (!op_q[2])
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    else if (div_borrow)
      acc_nxt = {acc[2*XLEN-2:0], 1'b0};
    else
      acc_nxt = {div_diff, acc[XLEN-2:0], 1'b1};
    prod      = neg_q ? -acc_nxt : acc_nxt;
    div_val   = op_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    div_fin   = neg_q ? -div_val : div_val;
    final_res = op_q[2] ? div_fin
              : (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  assign stall = !rst && ((state == S_IDLE && start && !flush) || state == S_CALC);

  // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_MUL;
      neg_q  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op_q  <= op_e'(op);
            neg_q <= is_rem ? sgn_a : (sgn_a ^ sgn_b);
            cnt   <= '0;
            if (special) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, mag_a};
              opnd  <= mag_b;
              busy  <= 1'b1;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
              result <= final_res;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_DONE;
            end
          end
        end
        // start seen here belongs to the instruction just completed.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
